// File: rtl/tx_frame_ctrl.sv
// Transmit frame controller: accepts one message, then sequences load, chip and
// bit-shift strobes for the spreading modulator until the frame completes or aborts.
module tx_frame_ctrl #(
  parameter int MSG_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  input  logic                 i_msg_valid,
  output logic                 o_msg_ready,
  input  logic [MSG_WIDTH-1:0] i_msg,
  input  logic [1:0]           i_spreading_factor,
  input  logic                 i_abort,
  output logic [MSG_WIDTH-1:0] o_msg,
  output logic [1:0]           o_spreading_factor,
  output logic                 o_load_msg,
  output logic                 o_shift_bit,
  output logic [4:0]           o_chip_idx,
  output logic                 o_chaos_en,
  output logic                 o_tx_valid,
  output logic                 o_frame_done,
  output logic                 o_busy
);

  localparam int BIT_W = $clog2(MSG_WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(MSG_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [4:0]       chip_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [4:0]       chip_last;
  logic             sym_end;
  logic             accept;

  // Symbol length is 2*SF chips: 4 << sf, decoded only from the latched SF.
  assign chip_last = 5'((6'd4 << o_spreading_factor) - 6'd1);
  assign sym_end   = (state == S_SEND) && (chip_cnt == chip_last);
  assign accept    = (state == S_IDLE) && i_msg_valid && !i_abort;

  always_comb begin
    state_nxt = state;
    if (i_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (i_msg_valid) state_nxt = S_LOAD;
        S_LOAD:  state_nxt = S_SEND;
        S_SEND:  if (sym_end && (bit_cnt == BIT_LAST)) state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state              <= S_IDLE;
      chip_cnt           <= '0;
      bit_cnt            <= '0;
      o_msg              <= '0;
      o_spreading_factor <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        o_msg              <= i_msg;
        o_spreading_factor <= i_spreading_factor;
      end
      if (i_abort || (state != S_SEND)) begin
        chip_cnt <= '0;
        bit_cnt  <= '0;
      end else if (sym_end) begin
        chip_cnt <= '0;
        if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + 1'b1;
      end else begin
        chip_cnt <= chip_cnt + 5'd1;
      end
    end
  end

  // Strobes that would commit work downstream are masked in an abort cycle.
  assign o_msg_ready  = (state == S_IDLE);
  assign o_busy       = (state != S_IDLE);
  assign o_load_msg   = (state == S_LOAD) && !i_abort;
  assign o_shift_bit  = sym_end && !i_abort;
  assign o_tx_valid   = (state == S_SEND);
  assign o_chaos_en   = (state == S_SEND);
  assign o_chip_idx   = (state == S_SEND) ? chip_cnt : 5'd0;
  assign o_frame_done = (state == S_DONE) && !i_abort;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Randomized bench for tx_frame_ctrl against a frame-position reference model.
module tb_tx_frame_ctrl;

  localparam int M = 32;

  logic         i_clk = 1'b0;
  logic         i_arst_n;
  logic         i_msg_valid;
  logic         o_msg_ready;
  logic [M-1:0] i_msg;
  logic [1:0]   i_spreading_factor;
  logic         i_abort;
  logic [M-1:0] o_msg;
  logic [1:0]   o_spreading_factor;
  logic         o_load_msg;
  logic         o_shift_bit;
  logic [4:0]   o_chip_idx;
  logic         o_chaos_en;
  logic         o_tx_valid;
  logic         o_frame_done;
  logic         o_busy;

  always #5 i_clk = ~i_clk;

  tx_frame_ctrl #(.MSG_WIDTH(M)) dut (
    .i_clk              (i_clk),
    .i_arst_n           (i_arst_n),
    .i_msg_valid        (i_msg_valid),
    .o_msg_ready        (o_msg_ready),
    .i_msg              (i_msg),
    .i_spreading_factor (i_spreading_factor),
    .i_abort            (i_abort),
    .o_msg              (o_msg),
    .o_spreading_factor (o_spreading_factor),
    .o_load_msg         (o_load_msg),
    .o_shift_bit        (o_shift_bit),
    .o_chip_idx         (o_chip_idx),
    .o_chaos_en         (o_chaos_en),
    .o_tx_valid         (o_tx_valid),
    .o_frame_done       (o_frame_done),
    .o_busy             (o_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a frame is a position t after acceptance:
  // t=0 load, t=1..M*L chips, t=M*L+1 done.
  bit         m_busy = 1'b0;
  int         m_t    = 0;
  logic [M-1:0] m_msg = '0;
  logic [1:0] m_sf   = 2'd0;

  int cnt_tx, cnt_shift, cnt_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sym_len(input logic [1:0] sf);
    return 2 * (2 << sf);
  endfunction

  task automatic check_outputs();
    int L, n_send, chip;
    logic e_load, e_shift, e_tx, e_done;
    logic [4:0] e_chip;
    L = sym_len(m_sf);
    n_send = M * L;
    e_load = 0; e_shift = 0; e_tx = 0; e_done = 0; e_chip = 5'd0;
    if (m_busy) begin
      if (m_t == 0) begin
        e_load = !i_abort;
      end else if (m_t <= n_send) begin
        chip    = (m_t - 1) % L;
        e_tx    = 1'b1;
        e_chip  = 5'(chip);
        e_shift = (chip == L - 1) && !i_abort;
      end else begin
        e_done = !i_abort;
      end
    end
    chk("msg_ready",  64'(o_msg_ready),        64'(!m_busy));
    chk("busy",       64'(o_busy),             64'(m_busy));
    chk("msg",        64'(o_msg),              64'(m_msg));
    chk("sf",         64'(o_spreading_factor), 64'(m_sf));
    chk("load_msg",   64'(o_load_msg),         64'(e_load));
    chk("shift_bit",  64'(o_shift_bit),        64'(e_shift));
    chk("tx_valid",   64'(o_tx_valid),         64'(e_tx));
    chk("chaos_en",   64'(o_chaos_en),         64'(e_tx));
    chk("chip_idx",   64'(o_chip_idx),         64'(e_chip));
    chk("frame_done", 64'(o_frame_done),       64'(e_done));
  endtask

  task automatic model_clock();
    if (i_abort) begin
      m_busy = 1'b0;
      m_t    = 0;
    end else if (!m_busy) begin
      if (i_msg_valid) begin
        m_busy = 1'b1;
        m_t    = 0;
        m_msg  = i_msg;
        m_sf   = i_spreading_factor;
      end
    end else begin
      m_t++;
      if (m_t > M * sym_len(m_sf) + 1) begin
        m_busy = 1'b0;
        m_t    = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_t    = 0;
    m_msg  = '0;
    m_sf   = 2'd0;
  endtask

  task automatic step();
    @(negedge i_clk);
    check_outputs();
    cnt_tx    += int'(o_tx_valid);
    cnt_shift += int'(o_shift_bit);
    cnt_done  += int'(o_frame_done);
    @(posedge i_clk);
    model_clock();
    #1;
  endtask

  task automatic run_to_idle(input int budget);
    int n;
    n = 0;
    while (m_busy && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(m_busy), 64'(0));
  endtask

  initial begin
    i_arst_n = 1'b0;
    i_msg_valid = 1'b0;
    i_abort = 1'b0;
    i_msg = '0;
    i_spreading_factor = 2'd0;
    cnt_tx = 0; cnt_shift = 0; cnt_done = 0;
    #2;
    check_outputs();
    #10 i_arst_n = 1'b1;
    @(posedge i_clk);
    #1;
    step();

    // Basic SF2 frame with a known message.
    i_msg = 32'hA5A5_0F0F; i_spreading_factor = 2'd0; i_msg_valid = 1'b1;
    step();
    i_msg_valid = 1'b0;
    cnt_tx = 0; cnt_shift = 0; cnt_done = 0;
    run_to_idle(400);
    chk("sf2_tx_count",    64'(cnt_tx),    64'(M * 4));
    chk("sf2_shift_count", 64'(cnt_shift), 64'(M));
    chk("sf2_done_count",  64'(cnt_done),  64'(1));

    // Abort together with a valid offer in IDLE: nothing captured.
    i_msg = $urandom; i_msg_valid = 1'b1; i_abort = 1'b1;
    step();
    i_abort = 1'b0; i_msg_valid = 1'b0;
    chk("abort_idle_msg",   64'(o_msg),       64'(32'hA5A5_0F0F));
    chk("abort_idle_ready", 64'(o_msg_ready), 64'(1));
    step();

    // SF4 frame aborted at bit 5, chip 3.
    i_msg = $urandom; i_spreading_factor = 2'd1; i_msg_valid = 1'b1;
    step();
    i_msg_valid = 1'b0;
    for (int n = 0; n < 200 && m_t < 1 + 5 * 8 + 3; n++) step();
    chk("abort_reach", 64'(m_t), 64'(1 + 5 * 8 + 3));
    i_abort = 1'b1;
    cnt_done = 0;
    step();
    i_abort = 1'b0;
    chk("abort_busy", 64'(o_busy),     64'(0));
    chk("abort_chip", 64'(o_chip_idx), 64'(0));
    step();
    chk("abort_no_done", 64'(cnt_done), 64'(0));

    // Random traffic: SF and message change every cycle, occasional abort.
    for (int i = 0; i < 15000; i++) begin
      i_msg_valid        = ($urandom_range(0, 3) == 0);
      i_abort            = ($urandom_range(0, 599) == 0);
      i_msg              = $urandom;
      i_spreading_factor = 2'($urandom_range(0, 3));
      step();
    end
    i_abort = 1'b0; i_msg_valid = 1'b0;
    run_to_idle(1100);

    // Asynchronous reset mid-frame, between clock edges.
    i_msg = $urandom; i_spreading_factor = 2'd2; i_msg_valid = 1'b1;
    step();
    i_msg_valid = 1'b0;
    for (int n = 0; n < 100 && m_t < 20; n++) step();
    chk("rst_reach_send", 64'(m_t), 64'(20));
    @(negedge i_clk);
    #2 i_arst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge i_clk);
    #1;
    check_outputs();
    @(negedge i_clk);
    #2 i_arst_n = 1'b1;
    @(posedge i_clk);
    #1;
    i_msg = $urandom; i_spreading_factor = 2'd2; i_msg_valid = 1'b1;
    step();
    i_msg_valid = 1'b0;
    i_spreading_factor = 2'd0;
    cnt_tx = 0; cnt_shift = 0; cnt_done = 0;
    run_to_idle(700);
    chk("post_rst_tx_count",    64'(cnt_tx),    64'(M * 16));
    chk("post_rst_shift_count", 64'(cnt_shift), 64'(M));
    chk("post_rst_done_count",  64'(cnt_done),  64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_frame_ctrl.md
TX_FRAME_CTRL -- requirements
Module: tx_frame_ctrl

Interface
REQ-001 SHALL have parameter MSG_WIDTH, default 32, giving message length in bits (>= 2).
REQ-002 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_arst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port i_msg_valid  input  1  a message is offered on i_msg.
REQ-005 SHALL have port o_msg_ready  output  1  controller accepts a message this cycle.
REQ-006 SHALL have port i_msg  input  MSG_WIDTH  message to transmit.
REQ-007 SHALL have port i_spreading_factor  input  2  requested SF (SF2=0, SF4=1, SF8=2, SF16=3, per spreading_factors_pkg).
REQ-008 SHALL have port i_abort  input  1  synchronous frame abort.
REQ-009 SHALL have port o_msg  output  MSG_WIDTH  captured message, held stable for the whole frame.
REQ-010 SHALL have port o_spreading_factor  output  2  SF latched at acceptance, held for the whole frame.
REQ-011 SHALL have port o_load_msg  output  1  one-cycle load strobe to the modulator's message shift register.
REQ-012 SHALL have port o_shift_bit  output  1  one-cycle pulse advancing the modulator to the next message bit.
REQ-013 SHALL have port o_chip_idx  output  5  chip index within the current symbol.
REQ-014 SHALL have port o_chaos_en  output  1  enables the chaos generator for one chip.
REQ-015 SHALL have port o_tx_valid  output  1  modulator serial output is a valid chip this cycle.
REQ-016 SHALL have port o_frame_done  output  1  one-cycle pulse at normal frame completion.
REQ-017 SHALL have port o_busy  output  1  a frame is in progress (any state other than IDLE).

Function
REQ-018 SHALL implement states IDLE, LOAD, SEND, DONE.
REQ-019 In IDLE: o_msg_ready=1. On i_msg_valid=1 with i_abort=0, o_msg<=i_msg, o_spreading_factor<=i_spreading_factor, next state LOAD.
REQ-020 In all states other than IDLE, o_msg_ready SHALL be 0, and i_msg_valid SHALL be ignored.
REQ-021 In LOAD: o_load_msg=1 for exactly this cycle; chip and bit counters clear; next state SEND.
REQ-022 Latency: handshake at edge N gives o_load_msg high in cycle N+1 and the first chip (o_tx_valid=1, o_chip_idx=0) in cycle N+2.
REQ-023 SHALL define the symbol length L = 2*SF chips (4/8/16/32), decoded from the latched o_spreading_factor only.
REQ-024 In SEND: o_tx_valid=1 and o_chaos_en=1 each cycle; o_chip_idx increments by 1 per cycle and wraps from L-1 to 0.
REQ-025 When o_chip_idx==L-1 in SEND: o_shift_bit=1 for that cycle and the bit counter increments.
REQ-026 SHALL size the bit counter at $clog2(MSG_WIDTH) bits; it counts 0..MSG_WIDTH-1 with no overflow.
REQ-027 When o_chip_idx==L-1 and bit counter==MSG_WIDTH-1: o_shift_bit=1 and next state DONE.
REQ-028 A frame SHALL occupy exactly MSG_WIDTH*L SEND cycles.
REQ-029 In DONE: o_frame_done=1 for one cycle, o_tx_valid=0, next state IDLE; the next message can be accepted in the following cycle.
REQ-030 Changes on i_spreading_factor or i_msg after acceptance SHALL NOT affect the frame in progress.
REQ-031 i_abort=1 in any state SHALL force the next state to IDLE, clear both counters, and suppress o_frame_done; o_load_msg and o_shift_bit SHALL be 0 in the abort cycle.
REQ-032 i_abort=1 together with i_msg_valid=1 in IDLE: abort wins; no capture; o_msg is unchanged.
REQ-033 Outside SEND: o_tx_valid=0, o_chaos_en=0, o_shift_bit=0, o_chip_idx=0.

Reset
REQ-034 On i_arst_n=0, immediately and regardless of clock: state=IDLE, counters=0, o_msg=0, o_spreading_factor=0, o_load_msg=0, o_shift_bit=0, o_tx_valid=0, o_chaos_en=0, o_frame_done=0, o_busy=0, o_msg_ready=1 (combinational from IDLE).
REQ-035 Reset asserted mid-frame SHALL discard the frame with no o_frame_done; after release, the block is in IDLE.

Verification
REQ-036 MSG_WIDTH=32, SF=0, i_msg=32'hA5A5_0F0F accepted at edge N -> o_load_msg in cycle N+1; 128 o_tx_valid cycles; 32 o_shift_bit pulses, every 4th chip; o_frame_done in cycle N+130.
REQ-037 SF=3 accepted, then i_spreading_factor toggled mid-frame -> o_chip_idx wraps at 31 throughout; 1024 valid chips; o_spreading_factor stays 3.
REQ-038 Second i_msg_valid held high during a frame -> o_msg_ready=0 and o_msg unchanged until DONE; the second message is accepted in the cycle after o_frame_done.
REQ-039 i_abort pulsed in the SF=1 frame at bit 5, chip 3 -> next cycle IDLE, o_busy=0, o_chip_idx=0, no o_frame_done.
REQ-040 i_arst_n dropped mid-SEND between clock edges -> all outputs reach their reset values before the next edge; a new frame after release runs to completion normally.
REQ-041 i_abort=1 and i_msg_valid=1 in the same IDLE cycle -> no LOAD, o_msg unchanged, o_msg_ready stays 1.
